// File: rtl/stream_mux_rr_pkg.sv
// Shared constants and types for the stream_mux_rr channel multiplexer.
// Statistics counters are present only when MUX_STATS_EN is defined.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    localparam int              STAT_W   = 16;
    localparam logic [STAT_W-1:0] STAT_MAX = 16'hFFFF;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Rotating-priority arbiter: grants the first requester at or after ptr,
// wrapping to channel 0. Output is one-hot or all-zero.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int N_CH  = 4,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N_CH-1:0]  gnt
);

    logic [N_CH-1:0] req_hi;

    // Requests at or above the pointer take precedence over the wrapped ones.
    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_mask
            assign req_hi[gi] = req[gi] && (SEL_W'(gi) >= ptr);
        end
    endgenerate

    always_comb begin
        logic found;
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (!found && req_hi[i]) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
        for (int i = 0; i < N_CH; i++) begin
            if (!found && req[i]) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with fixed-select and round-robin
// modes and a single registered output stage. Optional macro: MUX_STATS_EN.
module stream_mux_rr
    import mux_pkg::*;
#(
    parameter  int N_CH  = 4,
    parameter  int W     = 8,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mode,
    input  logic [SEL_W-1:0]    sel,
    input  logic [N_CH-1:0]     in_valid,
    input  logic [N_CH*W-1:0]   in_data,
    output logic [N_CH-1:0]     in_ready,
    output logic                out_valid,
    output logic [W-1:0]        out_data,
    output logic [SEL_W-1:0]    out_ch,
    input  logic                out_ready,
    input  logic [SEL_W-1:0]    stat_sel,
    output logic [STAT_W-1:0]   stat_cnt
);

    out_state_t       state_reg;
    logic [W-1:0]     data_reg;
    logic [SEL_W-1:0] ch_reg;
    logic [SEL_W-1:0] ptr_reg;
    logic [SEL_W-1:0] ptr_next;

    logic             load_en;
    logic             xfer;
    logic [N_CH-1:0]  fixed_gnt;
    logic [N_CH-1:0]  rr_gnt;
    logic [N_CH-1:0]  grant;
    logic [SEL_W-1:0] gnt_idx;
    logic [W-1:0]     gnt_data;

    assign out_valid = (state_reg == ST_FULL);
    assign out_data  = data_reg;
    assign out_ch    = ch_reg;

    // Pass-through: the register may reload in the same cycle it drains.
    assign load_en = !out_valid || out_ready;

    // An out-of-range sel matches no channel and therefore grants nothing.
    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_fixed
            assign fixed_gnt[gi] = in_valid[gi] && (sel == SEL_W'(gi));
        end
    endgenerate

    rr_arbiter #(.N_CH(N_CH)) u_arb (
        .req (in_valid),
        .ptr (ptr_reg),
        .gnt (rr_gnt)
    );

    assign grant    = (mode == MODE_RR) ? rr_gnt : fixed_gnt;
    assign in_ready = load_en ? grant : '0;
    assign xfer     = |in_ready;

    always_comb begin
        gnt_idx  = '0;
        gnt_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant[i]) begin
                gnt_idx  = SEL_W'(i);
                gnt_data = in_data[i*W +: W];
            end
        end
    end

    assign ptr_next = (gnt_idx == SEL_W'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_EMPTY;
            data_reg  <= '0;
            ch_reg    <= '0;
            ptr_reg   <= '0;
        end else if (load_en) begin
            if (xfer) begin
                state_reg <= ST_FULL;
                data_reg  <= gnt_data;
                ch_reg    <= gnt_idx;
                if (mode == MODE_RR) begin
                    ptr_reg <= ptr_next;
                end
            end else begin
                state_reg <= ST_EMPTY;
            end
        end
    end

`ifdef MUX_STATS_EN
    logic [STAT_W-1:0] cnt_reg [N_CH];

    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_stat
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_reg[gi] <= '0;
                end else if (in_ready[gi] && (cnt_reg[gi] != STAT_MAX)) begin
                    cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
                end
            end
        end
    endgenerate

    always_comb begin
        stat_cnt = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (stat_sel == SEL_W'(i)) begin
                stat_cnt = cnt_reg[i];
            end
        end
    end
`else
    logic unused_stat_sel;
    assign unused_stat_sel = ^stat_sel;
    assign stat_cnt        = '0;
`endif

endmodule
